// File: rtl/serial_subtractor_seq_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// SERIAL_SUB_OVERFLOW_EN adds the signed-overflow result bit.
interface serial_subtractor_seq_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;

  modport master (output start, a, b, borrow_in,
                  input  busy, done, diff, borrow_out, overflow);
  modport slave  (input  start, a, b, borrow_in,
                  output busy, done, diff, borrow_out, overflow);
`else
  modport master (output start, a, b, borrow_in,
                  input  busy, done, diff, borrow_out);
  modport slave  (input  start, a, b, borrow_in,
                  output busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor_seq.sv
// Bit-serial a - b - borrow_in, LSB first, one full-subtractor cell reused WIDTH times.
// Optional SERIAL_SUB_OVERFLOW_EN adds a two's-complement overflow flag held with diff.
module serial_subtractor_seq #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_subtractor_seq_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, wd_q, wd_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, bo_q, bo_d;
  logic             bit_d, br_nx;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             as_q, as_d, bs_q, bs_d, ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    as_d    = as_q;
    bs_d    = bs_q;
    ovf_d   = ovf_q;
`endif
    bit_d   = a_q[0] ^ b_q[0] ^ br_q;
    br_nx   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    case (state_q)
      // DONE accepts a new start just like IDLE, giving WIDTH+1 cycle throughput.
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.borrow_in;
          wd_d    = '0;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_SUB_OVERFLOW_EN
          as_d    = bus.a[WIDTH-1];
          bs_d    = bus.b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        wd_d  = {bit_d, wd_q[WIDTH-1:1]};
        br_d  = br_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          diff_d  = {bit_d, wd_q[WIDTH-1:1]};
          bo_d    = br_nx;
          state_d = DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
          // bit_d is the result sign bit on the final step.
          ovf_d   = (as_q != bs_q) && (bit_d != as_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      as_q    <= 1'b0;
      bs_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      as_q    <= as_d;
      bs_q    <= bs_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = (state_q == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bo_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign bus.overflow   = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor_seq.md
Name: serial_subtractor_seq

Overview:
- Bit-serial, clocked subtractor: computes diff = a - b - borrow_in, one bit per clock, LSB first, using a single borrow flip-flop.
- Inverse-direction counterpart to the team's ripple adders.
- Intended for area-constrained datapaths where one full-subtractor cell is reused over WIDTH cycles.
- Simple start/busy/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 4, operand and result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- borrow_in  input  1  initial borrow; captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; result valid.
- diff  output  WIDTH  result; held until the next completion.
- borrow_out  output  1  final borrow (1 = a < b + borrow_in, unsigned); held with diff.

Behaviour:
- Interface: one clock, clk; reset is asynchronous, active-low, rst_n.
- Reset (async assert, any state):
  - state=IDLE.
  - busy=0, done=0, diff=0, borrow_out=0.
  - Internal shift registers, borrow FF and bit counter cleared.
  - Any in-flight operation is discarded; no done is issued for it.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge k: capture a, b and borrow_in into working registers; counter=0; go to SHIFT.
  - busy=1 from edge k.
- SHIFT, one bit per edge:
  - Operate on bit i = LSB of the a/b working registers, with br = borrow FF.
  - d_i = a_i ^ b_i ^ br.
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - Shift d_i into the working diff register from the MSB side; right-shift the a/b registers; counter += 1.
  - Edges k+1 .. k+WIDTH process bits 0 .. WIDTH-1.
  - On the edge that processes bit WIDTH-1 (edge k+WIDTH):
    - Load diff and borrow_out from the working registers.
    - Go to DONE; busy=0, done=1.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge: if start=1, accept a new operation (same as IDLE, go to SHIFT); otherwise go to IDLE.
- Latency: done high in cycle k+WIDTH through k+WIDTH+1. Back-to-back throughput is one result per WIDTH+1 cycles.
- start while busy=1: ignored. Operands captured at acceptance are not affected by later input changes.
- diff and borrow_out change only at completion. Between completions they hold the last result, or 0 after reset.
- Arithmetic is modulo 2^WIDTH; borrow_out is the unsigned underflow indicator.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- Defined:
  - Extra output port overflow, 1 bit, reset 0, updated and held together with diff.
  - overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]), using the captured operands.
  - This is two's-complement signed overflow of a - b - borrow_in.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4; a=9, b=3, borrow_in=0, start pulse at edge k:
  - busy=1 at edges k..k+3, done=1 only in cycle k+4.
  - diff=6, borrow_out=0.
- a=3, b=9, borrow_in=0 -> diff=0xA, borrow_out=1.
- a=0, b=0, borrow_in=1 -> diff=0xF, borrow_out=1.
- a=5, b=5, borrow_in=0 -> diff=0, borrow_out=0.
- Start a=9, b=3; at edge k+2 pulse start with a=1, b=2 -> second start ignored; diff=6 at done.
  - Then start in the DONE cycle with a=1, b=2 -> accepted immediately; next result diff=0xF, borrow_out=1.
- Reset and overflow checks:
  - Assert rst_n=0 mid-SHIFT -> busy, done, diff and borrow_out go to 0 immediately.
  - After release, no done pulse until a new start.
  - With SERIAL_SUB_OVERFLOW_EN: a=8, b=1 -> diff=7, overflow=1.
  - a=7, b=0xF -> diff=8, overflow=1, borrow_out=1.
  - a=6, b=2 -> overflow=0.
